// File: rtl/parameterized_byte_enable_ram_pkg.sv
// Shared types, read-during-write constants and the byte-lane merge helper
// for parameterized_byte_enable_ram (debug macro: PARAMETERIZED_RAM_DISPLAY_EN).
package parameterized_byte_enable_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MERGE_W    = 1024;
    localparam int MERGE_BE_W = MERGE_W / 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] result;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/parameterized_byte_enable_ram_init_sequencer.sv
// Init sweep controller: owns state, init_cnt, init_done and the array write-port mux.
// Optional sweep-end message under PARAMETERIZED_RAM_DISPLAY_EN.
module ram_init_sequencer
    import parameterized_byte_enable_ram_pkg::*;
#(
    parameter int                  SIZE          = 4096,
    parameter int                  ADDRESS_SPACE = 12,
    parameter int                  DATA_SIZE     = 32,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     user_we,
    input  logic [ADDRESS_SPACE-1:0] user_addr,
    input  logic [DATA_SIZE/8-1:0]   user_be,
    input  logic [DATA_SIZE-1:0]     user_wdata,
    output logic                     ready,
    output logic                     init_done,
    output logic                     mem_we,
    output logic [ADDRESS_SPACE-1:0] mem_addr,
    output logic [DATA_SIZE/8-1:0]   mem_be,
    output logic [DATA_SIZE-1:0]     mem_wdata
);

    localparam logic [ADDRESS_SPACE-1:0] LAST_ADDR = ADDRESS_SPACE'(SIZE - 1);

    state_e                   state, state_next;
    logic [ADDRESS_SPACE-1:0] init_cnt, cnt_next;
    logic                     done_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            init_cnt  <= cnt_next;
            init_done <= done_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = init_cnt;
        done_next  = init_done;
        case (state)
            ST_INIT: begin
                if (clr) begin
                    cnt_next = '0;
                end else if (init_cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = init_cnt + ADDRESS_SPACE'(1);
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign ready = (state == ST_READY) && !clr;

    always_comb begin
        mem_we    = user_we;
        mem_addr  = user_addr;
        mem_be    = user_be;
        mem_wdata = user_wdata;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = init_cnt;
            mem_be    = '1;
            mem_wdata = INIT_VALUE;
        end
    end

`ifdef PARAMETERIZED_RAM_DISPLAY_EN
    always @(posedge clk) begin
        if (rst_n && state == ST_INIT && !clr && init_cnt == LAST_ADDR)
            $display("[%m] init sweep complete (%0d words)", SIZE);
    end
`endif

endmodule

// File: rtl/parameterized_byte_enable_ram.sv
// Single-port byte-enable RAM with valid/ready requests, selectable read-during-write,
// optional output register and init sweep. Debug prints: PARAMETERIZED_RAM_DISPLAY_EN.
module parameterized_byte_enable_ram
    import parameterized_byte_enable_ram_pkg::*;
#(
    parameter int                   SIZE          = 4096,
    parameter int                   ADDRESS_SPACE = 12,
    parameter int                   DATA_SIZE     = 32,
    parameter int                   RDW_MODE      = 0,
    parameter int                   OUTPUT_REG    = 0,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [DATA_SIZE/8-1:0]   req_be,
    input  logic [ADDRESS_SPACE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]     req_din,
    output logic                     rsp_valid,
    output logic [DATA_SIZE-1:0]     rsp_dout,
    output logic                     rsp_err,
    output logic                     init_done
);

    localparam int BE_W  = DATA_SIZE / 8;
    localparam int IDX_W = $clog2(SIZE);

    if (DATA_SIZE % 8 != 0 || DATA_SIZE > MERGE_W) begin : g_bad_width
        $error("DATA_SIZE must be a multiple of 8 and at most MERGE_W");
    end
    if (SIZE < 2 || SIZE > 2 ** ADDRESS_SPACE) begin : g_bad_size
        $error("SIZE must lie in 2..2**ADDRESS_SPACE");
    end
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
        $error("RDW_MODE must be 0 or 1");
    end

    logic                     accept, in_range, user_we;
    logic                     mem_we;
    logic [ADDRESS_SPACE-1:0] mem_addr;
    logic [BE_W-1:0]          mem_be;
    logic [DATA_SIZE-1:0]     mem_wdata;
    logic [IDX_W-1:0]         req_idx, wr_idx;
    logic [DATA_SIZE-1:0]     mem [SIZE];

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < (ADDRESS_SPACE + 1)'(SIZE);
    assign user_we  = accept && req_we && in_range;
    assign req_idx  = req_addr[IDX_W-1:0];
    assign wr_idx   = mem_addr[IDX_W-1:0];

    ram_init_sequencer #(
        .SIZE          (SIZE),
        .ADDRESS_SPACE (ADDRESS_SPACE),
        .DATA_SIZE     (DATA_SIZE),
        .INIT_VALUE    (INIT_VALUE)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .user_we    (user_we),
        .user_addr  (req_addr),
        .user_be    (req_be),
        .user_wdata (req_din),
        .ready      (req_ready),
        .init_done  (init_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata)
    );

    // NOTE: the array carries no reset; the init sweep gives it a defined value instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) mem[wr_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    logic                 s1_valid, s1_err;
    logic [DATA_SIZE-1:0] s1_data;

    // The array read here sees the pre-write word, which is what READ_FIRST returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err <= !in_range;
                if (!in_range)
                    s1_data <= '0;
                else if (req_we && RDW_MODE == RDW_WRITE_FIRST)
                    s1_data <= DATA_SIZE'(merge(MERGE_W'(mem[req_idx]), MERGE_W'(req_din),
                                                MERGE_BE_W'(req_be)));
                else
                    s1_data <= mem[req_idx];
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                 s2_valid, s2_err;
        logic [DATA_SIZE-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_err  <= s1_err;
                    s2_data <= s1_data;
                end
            end
        end

        assign rsp_valid = s2_valid;
        assign rsp_dout  = s2_data;
        assign rsp_err   = s2_err;
    end else begin : g_no_out_reg
        assign rsp_valid = s1_valid;
        assign rsp_dout  = s1_data;
        assign rsp_err   = s1_err;
    end

`ifdef PARAMETERIZED_RAM_DISPLAY_EN
    logic [ADDRESS_SPACE-1:0] s1_addr, s2_addr;

    always @(posedge clk) begin
        if (accept) s1_addr <= req_addr;
        s2_addr <= s1_addr;
        if (user_we)
            $display("[%m] write addr=%h be=%b data=%h", req_addr, req_be,
                     DATA_SIZE'(merge(MERGE_W'(mem[req_idx]), MERGE_W'(req_din), MERGE_BE_W'(req_be))));
        if (rsp_valid)
            $display("[%m] rsp addr=%h data=%h err=%b",
                     (OUTPUT_REG != 0) ? s2_addr : s1_addr, rsp_dout, rsp_err);
    end
`endif

endmodule
